mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported unified memory between the instruction-fetch (IF) port and the data (MEM-stage) port of the 5-stage CPU pipeline. It serialises the two requesters and drives a variable-latency req/ack memory interface. It also generates a global pipeline stall that freezes PC, IFID, IDEX, EXMEM and MEMWB until every outstanding access of the current cycle has been served. It replaces the separate Instruction_Memory/Data_Memory connection when the CPU runs from a shared memory.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; level, held while pipeline is stalled
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_ack_o  out  1  one-cycle pulse: fetch completed
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ack_o=1, held afterwards
- d_req_i  in  1  data request (load or store); level
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address (EXMEM ALU result)
- d_wdata_i  in  DATA_W  store data
- d_ack_o  out  1  one-cycle pulse: data access completed
- d_rdata_o  out  DATA_W  load data; valid while d_ack_o=1, held afterwards
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i
- stall_o  out  1  pipeline freeze (combinational)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Served flags if_srv and d_srv:
  - Each is set with the port's ack.
  - Both clear at the end of any cycle with stall_o=0, when the pipeline advances.
- Pending signals: pend_i = if_req_i & ~if_srv; pend_d = d_req_i & ~d_srv.
- stall_o = pend_i | pend_d.
- IDLE:
  - If pend_d, go to BUSY_D. Data has fixed priority because it is the older instruction.
  - Else if pend_i, go to BUSY_I.
  - On entry to BUSY_*, register mem_req_o=1, mem_addr_o, mem_we_o (0 for fetch) and mem_wdata_o from the granted port.
- BUSY_x:
  - Hold all mem_* outputs stable until mem_ack_i=1.
  - On mem_ack_i: drop mem_req_o, go to IDLE, pulse x_ack_o, register mem_rdata_i into x_rdata_o, set x_srv.
- No preemption: a data request arriving during BUSY_I waits for the fetch to finish.
- Port inputs are sampled only at grant. Changes while BUSY are ignored.
- Store ack: d_rdata_o holds its previous value.

## Timing
- Reset values: FSM=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_ack_o=0, d_ack_o=0, if_rdata_o=0, d_rdata_o=0, if_srv=d_srv=0. stall_o follows the inputs.
- Single access with a zero-wait memory:
  - pend at cycle 0
  - mem_req_o=1 in cycle 1, with mem_ack_i=1 in cycle 1
  - x_ack_o and valid data in cycle 2; FSM back in IDLE in cycle 2
- Memory with W wait cycles: ack_o arrives in cycle 2+W.
- Both ports pending in cycle 0:
  - d_ack_o in cycle 2
  - next grant from IDLE in cycle 2, mem_req_o=1 in cycle 3
  - if_ack_o in cycle 4
  - stall_o=1 in cycles 0–3, 0 in cycle 4
- Once served, a port is not re-granted while the frozen pipeline keeps its req high.
- Reset asserted mid-access: mem_req_o drops asynchronously and the access is abandoned. The memory must tolerate a withdrawn request.
- mem_ack_i while mem_req_o=0 is ignored.

## Configuration
- ARB_PERF_CNT_EN defined: adds two 32-bit outputs, both reset to 0 and saturating at 0xFFFFFFFF:
  - stall_cnt_o counts cycles with stall_o=1.
  - conflict_cnt_o counts IDLE cycles with pend_i & pend_d.
- ARB_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Fetch only, zero-wait memory, if_addr_i=0x40, mem_rdata_i=0x8C220004 -> mem_addr_o=0x40 in cycle 1, if_ack_o pulse with if_rdata_o=0x8C220004 in cycle 2, stall_o=0 in cycle 2.
- Both ports request in cycle 0: load at 0x100, fetch at 0x44 -> data granted first, d_ack_o in cycle 2, if_ack_o in cycle 4, stall_o high cycles 0–3; conflict_cnt_o=1 with ARB_PERF_CNT_EN.
- Store d_we_i=1, addr 0x20, wdata 0xDEADBEEF, memory W=3 -> mem_we_o=1 and mem_* stable for cycles 1–4, d_ack_o in cycle 5, d_rdata_o unchanged.
- Data request raised while BUSY_I, W=2 -> fetch finishes (if_ack_o cycle 4), data granted next, no re-grant of fetch while if_req_i stays high.
- rst_i driven low in cycle 2 of a W=5 access -> mem_req_o=0 immediately, no ack pulse, all outputs at reset values; after release, a fresh request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported req/ack memory
// and freezes the pipeline until both ports are served. Define ARB_PERF_CNT_EN for perf counters.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       conflict_cnt_o
`endif
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

   state_t            state_reg, state_next;
   logic              if_srv_reg, if_srv_next, d_srv_reg, d_srv_next;
   logic              if_ack_reg, if_ack_next, d_ack_reg, d_ack_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic [DATA_W-1:0] if_rdata_reg, if_rdata_next, d_rdata_reg, d_rdata_next;
   logic              pend_i, pend_d, grant_i, grant_d;

   assign pend_i  = if_req_i & ~if_srv_reg;
   assign pend_d  = d_req_i & ~d_srv_reg;
   assign stall_o = pend_i | pend_d;
   // Data wins a tie: it belongs to the older instruction in the pipeline.
   assign grant_d = (state_reg == IDLE) & pend_d;
   assign grant_i = (state_reg == IDLE) & ~pend_d & pend_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg     <= IDLE;
         if_srv_reg    <= 1'b0;
         d_srv_reg     <= 1'b0;
         if_ack_reg    <= 1'b0;
         d_ack_reg     <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         if_rdata_reg  <= '0;
         d_rdata_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         if_srv_reg    <= if_srv_next;
         d_srv_reg     <= d_srv_next;
         if_ack_reg    <= if_ack_next;
         d_ack_reg     <= d_ack_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         if_rdata_reg  <= if_rdata_next;
         d_rdata_reg   <= d_rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant_d)      state_next = BUSY_D;
            else if (grant_i) state_next = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      if_ack_next    = (state_reg == BUSY_I) & mem_ack_i;
      d_ack_next     = (state_reg == BUSY_D) & mem_ack_i;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      if (grant_d) begin
         mem_we_next    = d_we_i;
         mem_addr_next  = d_addr_i;
         mem_wdata_next = d_wdata_i;
      end else if (grant_i) begin
         mem_we_next    = 1'b0;
         mem_addr_next  = if_addr_i;
      end
      if_rdata_next = if_ack_next ? mem_rdata_i : if_rdata_reg;
      // A store completion leaves the last load data visible.
      d_rdata_next  = (d_ack_next & ~mem_we_reg) ? mem_rdata_i : d_rdata_reg;
      // Served flags survive the frozen pipeline and drop once it advances.
      if_srv_next   = if_ack_next | (if_srv_reg & stall_o);
      d_srv_next    = d_ack_next | (d_srv_reg & stall_o);
   end

   assign mem_req_o   = (state_reg != IDLE);
   assign mem_we_o    = mem_we_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_wdata_o = mem_wdata_reg;
   assign if_ack_o    = if_ack_reg;
   assign d_ack_o     = d_ack_reg;
   assign if_rdata_o  = if_rdata_reg;
   assign d_rdata_o   = d_rdata_reg;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_cnt_reg, conflict_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_reg    <= '0;
         conflict_cnt_reg <= '0;
      end else begin
         if (stall_o && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if ((state_reg == IDLE) && pend_i && pend_d && (conflict_cnt_reg != 32'hFFFF_FFFF))
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o    = stall_cnt_reg;
   assign conflict_cnt_o = conflict_cnt_reg;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a timestamp-based model of grants/acks/served flags is
// compared every cycle, plus literal expectations from the hand-worked scenarios.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'hBAD0_BAD0;
   logic        if_ack, d_ack, mem_req, mem_we, stall;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_cnt, conflict_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wait_w = 0;
   int wcnt = 0;
   bit spurious = 1'b0;
   bit armed = 1'b0;

   // model state: last grant and its completion cycle, served flags, expected read data
   bit          m_srv_i, m_srv_d, m_port_d, m_we;
   int          m_grant = -10, m_done = -1;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rd_i = '0, m_rd_d = '0;
   logic [31:0] m_stall_cnt = '0, m_conf_cnt = '0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_ack_o(d_ack), .d_rdata_o(d_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .stall_o(stall)
`ifdef ARB_PERF_CNT_EN
      , .stall_cnt_o(stall_cnt), .conflict_cnt_o(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C22_0004;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // memory responder: acks after wait_w wait cycles; optional stray ack while idle
   initial forever begin
      @(negedge clk);
      if (mem_req) begin
         if (wcnt >= wait_w) begin
            mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); wcnt = 0;
         end else begin
            mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0; wcnt++;
         end
      end else begin
         mem_ack = spurious; mem_rdata = 32'hBAD0_BAD0; wcnt = 0;
      end
   end

   // model update at the end of each cycle, then advance the cycle index
   initial forever begin
      bit pi, pd, st, idle;
      @(posedge clk);
      if (!rst_i) begin
         m_srv_i = 0; m_srv_d = 0; m_port_d = 0; m_we = 0;
         m_grant = -10; m_done = -1;
         m_addr = '0; m_wdata = '0; m_rd_i = '0; m_rd_d = '0;
         m_stall_cnt = '0; m_conf_cnt = '0;
      end else begin
         pi = if_req && !m_srv_i;
         pd = d_req && !m_srv_d;
         st = pi || pd;
         idle = (cyc >= m_done);
         if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
         if (idle && pi && pd && m_conf_cnt != 32'hFFFF_FFFF) m_conf_cnt = m_conf_cnt + 1;
         if (!st) begin m_srv_i = 0; m_srv_d = 0; end
         if (idle && (pi || pd)) begin
            m_port_d = pd;
            m_grant  = cyc;
            m_done   = cyc + 2 + wait_w;
            m_addr   = pd ? d_addr : if_addr;
            m_we     = pd ? d_we : 1'b0;
            m_wdata  = d_wdata;
         end
         if (m_done == cyc + 1) begin
            if (m_port_d) begin
               m_srv_d = 1;
               if (!m_we) m_rd_d = mem_word(m_addr);
            end else begin
               m_srv_i = 1;
               m_rd_i = mem_word(m_addr);
            end
         end
      end
      cyc++;
   end

   // compare process
   initial forever begin
      bit active;
      @(negedge clk);
      if (armed) begin
         if (!rst_i) begin
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk1("rst_if_ack", if_ack, 1'b0);
            chk1("rst_d_ack", d_ack, 1'b0);
            chk("rst_if_rdata", if_rdata, 32'h0);
            chk("rst_d_rdata", d_rdata, 32'h0);
            chk1("rst_stall", stall, if_req | d_req);
`ifdef ARB_PERF_CNT_EN
            chk("rst_stall_cnt", stall_cnt, 32'h0);
            chk("rst_conflict_cnt", conflict_cnt, 32'h0);
`endif
         end else begin
            active = (cyc > m_grant) && (cyc < m_done);
            chk1("mem_req", mem_req, active);
            if (active) begin
               chk("mem_addr", mem_addr, m_addr);
               chk1("mem_we", mem_we, m_we);
               if (m_port_d) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk1("if_ack", if_ack, (cyc == m_done) && !m_port_d);
            chk1("d_ack", d_ack, (cyc == m_done) && m_port_d);
            chk("if_rdata", if_rdata, m_rd_i);
            chk("d_rdata", d_rdata, m_rd_d);
            chk1("stall", stall, (if_req && !m_srv_i) || (d_req && !m_srv_d));
`ifdef ARB_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall_cnt);
            chk("conflict_cnt", conflict_cnt, m_conf_cnt);
`endif
            if (if_ack) $display("cycle %0d: fetch ack rdata=%h", cyc, if_rdata);
            if (d_ack)  $display("cycle %0d: data ack we=%b rdata=%h", cyc, mem_we, d_rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_i = 1'b0;
      armed = 1'b1;
      repeat (3) nxt();
      @(negedge clk);
      chk1("init_mem_req", mem_req, 1'b0);
      chk("init_d_rdata", d_rdata, 32'h0);
      nxt(); rst_i = 1'b1;
      repeat (2) nxt();

      // fetch only, zero-wait memory
      wait_w = 0; if_req = 1; if_addr = 32'h40;
      @(negedge clk); chk1("t1_stall_c0", stall, 1'b1);
      nxt(); @(negedge clk);
      chk1("t1_req_c1", mem_req, 1'b1); chk("t1_addr_c1", mem_addr, 32'h40);
      nxt(); @(negedge clk);
      chk1("t1_ack_c2", if_ack, 1'b1); chk("t1_rdata_c2", if_rdata, 32'h8C22_0004);
      chk1("t1_stall_c2", stall, 1'b0);
      nxt(); if_req = 0;
      @(negedge clk); chk1("t1_ack_c3", if_ack, 1'b0);
      nxt();

      // stray memory acks while idle are ignored
      spurious = 1;
      repeat (3) begin
         @(negedge clk); chk1("spur_ack", if_ack | d_ack, 1'b0);
         nxt();
      end
      spurious = 0;
      nxt();

      // both ports in cycle 0: load 0x100 first, fetch 0x44 after
      d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h44;
      @(negedge clk); chk1("t2_stall_c0", stall, 1'b1);
      nxt(); @(negedge clk); chk("t2_addr_c1", mem_addr, 32'h100);
      nxt(); @(negedge clk);
      chk1("t2_dack_c2", d_ack, 1'b1); chk("t2_drdata_c2", d_rdata, 32'h5A5A_0100);
      chk1("t2_stall_c2", stall, 1'b1);
`ifdef ARB_PERF_CNT_EN
      chk("t2_conflict", conflict_cnt, 32'd1);
`endif
      nxt(); @(negedge clk);
      chk1("t2_req_c3", mem_req, 1'b1); chk("t2_addr_c3", mem_addr, 32'h44);
      chk1("t2_stall_c3", stall, 1'b1);
      nxt(); @(negedge clk);
      chk1("t2_iack_c4", if_ack, 1'b1); chk("t2_irdata_c4", if_rdata, 32'h5A5A_0044);
      chk1("t2_stall_c4", stall, 1'b0);
      nxt(); d_req = 0; if_req = 0;
      nxt();

      // store with three wait cycles
      wait_w = 3; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      nxt();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk1("t3_req", mem_req, 1'b1); chk1("t3_we", mem_we, 1'b1);
         chk("t3_addr", mem_addr, 32'h20); chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
         nxt();
      end
      @(negedge clk);
      chk1("t3_dack_c5", d_ack, 1'b1); chk("t3_drdata_c5", d_rdata, 32'h5A5A_0100);
      chk1("t3_stall_c5", stall, 1'b0);
      nxt(); d_req = 0; d_we = 0;
      nxt();

      // data request arrives while the fetch is in flight
      wait_w = 2; if_req = 1; if_addr = 32'h48;
      nxt(); d_req = 1; d_we = 0; d_addr = 32'h104; if_addr = 32'h99;
      nxt(); @(negedge clk); chk("t4_addr_c2", mem_addr, 32'h48);
      nxt(); nxt(); @(negedge clk);
      chk1("t4_iack_c4", if_ack, 1'b1); chk("t4_irdata_c4", if_rdata, 32'h5A5A_0048);
      chk1("t4_stall_c4", stall, 1'b1);
      nxt(); @(negedge clk); chk("t4_addr_c5", mem_addr, 32'h104); chk1("t4_we_c5", mem_we, 1'b0);
      nxt(); @(negedge clk); chk("t4_addr_c6", mem_addr, 32'h104);
      nxt(); nxt(); @(negedge clk);
      chk1("t4_dack_c8", d_ack, 1'b1); chk1("t4_iack_c8", if_ack, 1'b0);
      chk("t4_drdata_c8", d_rdata, 32'h5A5A_0104); chk1("t4_stall_c8", stall, 1'b0);
      nxt(); d_req = 0; if_req = 0;
      nxt();

      // reset during a five-wait access
      wait_w = 5; if_req = 1; if_addr = 32'h50;
      nxt(); @(negedge clk); chk1("t5_req_c1", mem_req, 1'b1);
      nxt(); rst_i = 0; if_req = 0;
      @(negedge clk);
      chk1("t5_req_rst", mem_req, 1'b0); chk1("t5_ack_rst", if_ack, 1'b0);
      chk("t5_addr_rst", mem_addr, 32'h0); chk("t5_drdata_rst", d_rdata, 32'h0);
      nxt(); nxt(); rst_i = 1;
      nxt();
      wait_w = 0; d_req = 1; d_we = 0; d_addr = 32'h108;
      nxt(); @(negedge clk); chk1("t5_req_after", mem_req, 1'b1);
      nxt(); @(negedge clk);
      chk1("t5_dack_after", d_ack, 1'b1); chk("t5_drdata_after", d_rdata, 32'h5A5A_0108);
      chk("t5_irdata_after", if_rdata, 32'h0);
      nxt(); d_req = 0;
      repeat (3) nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
